// File: rtl/ntt_poly_mem_server.sv
// Two-bank coefficient memory that serves ntt_memory_wrapper's paired accesses (a, a+N/2),
// with host load/unload streams. Optional range checking is enabled by PMEM_ADDR_CHECK_EN.
module ntt_poly_mem_server #(
    parameter int unsigned LOGQ       = 64,
    parameter int unsigned LOGN       = 4,
    parameter int unsigned DELAY_BRAM = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                host_load_valid,
    output logic                                host_load_ready,
    input  logic [LOGQ-1:0]                     host_load_data,
    input  logic                                host_go,
    input  logic                                host_intt,
    output logic                                ntt_start,
    output logic                                ntt_intt,
    input  logic [((LOGN < 9) ? 9 : LOGN):0]    ntt_read_address,
    input  logic [((LOGN < 9) ? 9 : LOGN):0]    ntt_write_address,
    input  logic                                ntt_wea,
    output logic [LOGQ-1:0]                     ntt_data_in_0,
    output logic [LOGQ-1:0]                     ntt_data_in_1,
    input  logic                                ntt_finish,
    input  logic [LOGQ-1:0]                     ntt_data_out_0,
    input  logic [LOGQ-1:0]                     ntt_data_out_1,
    output logic                                unload_valid,
    input  logic                                unload_ready,
    output logic [LOGQ-1:0]                     unload_data,
    output logic                                unload_last,
    output logic                                busy,
    output logic                                err_addr
);

    localparam int unsigned AW      = ((LOGN < 9) ? 9 : LOGN) + 1;
    localparam int unsigned N       = 1 << LOGN;
    localparam int unsigned HALF    = N / 2;
    localparam int unsigned HW      = LOGN - 1;
    localparam int unsigned LastI   = N - 1;
    localparam logic [LOGN-1:0] LastIdx  = LastI[LOGN-1:0];
    localparam logic [LOGN:0]   LastFtch = LastI[LOGN:0];
    localparam logic [LOGN:0]   NumCoef  = N[LOGN:0];

    typedef enum logic [1:0] {StIdle, StLoaded, StRun, StUnload} state_e;

    state_e state_q, state_d;

    logic [LOGQ-1:0] bank0 [HALF];
    logic [LOGQ-1:0] bank1 [HALF];

    logic [LOGN-1:0] load_cnt_q, load_cnt_d;
    logic            load_ready_q;
    logic            start_q, intt_q;
    logic [LOGN:0]   fetch_cnt_q;
    logic            f_valid_q, f_last_q;
    logic [LOGQ-1:0] f_data_q, fetch_data;
    logic            out_valid_q, out_last_q;
    logic [LOGQ-1:0] out_data_q;
    logic [LOGQ-1:0] rd0_q, rd1_q;
    logic            err_q;
    logic            rd_bad, wr_bad;

    logic          load_fire, out_fire, out_load, fetch_en, unload_done, run_write;
    logic [HW-1:0] rd_idx, wr_idx;

    assign rd_idx = ntt_read_address[HW-1:0];
    assign wr_idx = ntt_write_address[HW-1:0];

`ifdef PMEM_ADDR_CHECK_EN
    assign rd_bad = |ntt_read_address[AW-1:HW];
    assign wr_bad = |ntt_write_address[AW-1:HW];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^{ntt_read_address[AW-1:HW], ntt_write_address[AW-1:HW]};
    assign rd_bad = 1'b0;
    assign wr_bad = 1'b0;
`endif

    assign load_fire   = (state_q == StIdle) && host_load_valid && load_ready_q;
    assign run_write   = (state_q == StRun) && ntt_wea && !wr_bad;
    assign out_fire    = out_valid_q && unload_ready;
    assign out_load    = (state_q == StUnload) && f_valid_q && (!out_valid_q || unload_ready);
    assign fetch_en    = (state_q == StUnload) && (fetch_cnt_q < NumCoef)
                         && (!f_valid_q || out_load);
    assign unload_done = out_fire && out_last_q;
    assign fetch_data  = fetch_cnt_q[HW] ? bank1[fetch_cnt_q[HW-1:0]]
                                         : bank0[fetch_cnt_q[HW-1:0]];

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (load_fire) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LastIdx) state_d = StLoaded;
                end
            end
            StLoaded: if (host_go) state_d = StRun;
            StRun:    if (ntt_finish) state_d = StUnload;
            StUnload: begin
                if (unload_done) begin
                    state_d    = StIdle;
                    load_cnt_d = '0;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            load_cnt_q   <= '0;
            load_ready_q <= 1'b0;
            start_q      <= 1'b0;
            intt_q       <= 1'b0;
            fetch_cnt_q  <= '0;
            f_valid_q    <= 1'b0;
            f_last_q     <= 1'b0;
            f_data_q     <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            load_ready_q <= (state_d == StIdle);
            if (state_q == StLoaded && host_go) begin
                intt_q  <= host_intt;
                start_q <= 1'b1;
            end else if (state_q == StRun && ntt_finish) begin
                start_q <= 1'b0;
            end
            if (state_q != StUnload) begin
                fetch_cnt_q <= '0;
                f_valid_q   <= 1'b0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                // Two-stage pipe: fetch register feeds the output register, both stall on !ready.
                if (fetch_en) begin
                    f_data_q    <= fetch_data;
                    f_last_q    <= (fetch_cnt_q == LastFtch);
                    f_valid_q   <= 1'b1;
                    fetch_cnt_q <= fetch_cnt_q + 1'b1;
                end else if (out_load) begin
                    f_valid_q <= 1'b0;
                end
                if (out_load) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= f_data_q;
                    out_last_q  <= f_last_q;
                end else if (out_fire) begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            end
        end
    end

    // Memory contents survive reset; nonblocking reads below give read-first behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_fire) begin
                if (load_cnt_q[HW]) bank1[load_cnt_q[HW-1:0]] <= host_load_data;
                else                bank0[load_cnt_q[HW-1:0]] <= host_load_data;
            end else if (run_write) begin
                bank0[wr_idx] <= ntt_data_out_0;
                bank1[wr_idx] <= ntt_data_out_1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else if (state_q == StRun) begin
            rd0_q <= rd_bad ? '0 : bank0[rd_idx];
            rd1_q <= rd_bad ? '0 : bank1[rd_idx];
        end
    end

    generate
        if (DELAY_BRAM == 2) begin : g_delay2
            logic [LOGQ-1:0] rd0_d2_q, rd1_d2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd0_d2_q <= '0;
                    rd1_d2_q <= '0;
                end else begin
                    rd0_d2_q <= rd0_q;
                    rd1_d2_q <= rd1_q;
                end
            end
            assign ntt_data_in_0 = rd0_d2_q;
            assign ntt_data_in_1 = rd1_d2_q;
        end else begin : g_delay1
            assign ntt_data_in_0 = rd0_q;
            assign ntt_data_in_1 = rd1_q;
        end
    endgenerate

`ifdef PMEM_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == StRun && (rd_bad || wr_bad)) begin
            err_q <= 1'b1;
        end
    end
    assign err_addr = err_q;
`else
    assign err_q    = 1'b0;
    assign err_addr = err_q;
`endif

    assign host_load_ready = load_ready_q;
    assign ntt_start       = start_q;
    assign ntt_intt        = intt_q;
    assign unload_valid    = out_valid_q;
    assign unload_data     = out_data_q;
    assign unload_last     = out_last_q;
    assign busy            = (state_q != StIdle);

endmodule
